csr_timer_intc: RTL and testbench

Parametrised timer and interrupt-pending CSR unit: NTIMER independent countdown timers plus NHWI sampled hardware interrupt lines. Each source has a pending bit and a mask bit, and the unit produces a combined `has_int` for the exception logic in the writeback stage. It sits beside the CSR register file and is accessed through the same masked read/write CSR port. It extends the single-timer TCFG/TVAL/TICLR behaviour with:
- multiple timer channels;
- a configurable counter width;
- a shared prescaler;
- per-source masking.

---
 rtl/csr_timer_pkg.sv | 23 ++
 rtl/csr_timer_intc_if.sv | 11 +
 rtl/csr_timer_chan.sv | 62 ++++++
 rtl/csr_timer_intc.sv | 118 +++++++++++
 tb/tb_csr_timer_intc.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/csr_timer_pkg.sv
// rtl/csr_timer_pkg.sv - CSR offsets, TCFG field positions and parameter range checks
package csr_timer_pkg;

   localparam int CHAN_STRIDE   = 4;
   localparam int OFF_TCFG      = 0;
   localparam int OFF_TVAL      = 1;
   localparam int OFF_TICLR     = 2;
   localparam int OFF_IMASK     = 16;
   localparam int OFF_IPEND     = 17;

   localparam int TCFG_EN_BIT   = 0;
   localparam int TCFG_PER_BIT  = 1;
   localparam int TCFG_INIT_LSB = 2;

   function automatic bit presc_ok(input int p);
      return (p >= 1) && (p <= 256);
   endfunction

   function automatic bit cnt_w_ok(input int w);
      return (w >= 8) && (w <= 32);
   endfunction

endpackage

// File: rtl/csr_timer_intc_if.sv
// rtl/csr_timer_intc_if.sv - masked CSR read/write port shared with the CSR register file
interface csr_timer_intc_if;
   logic [13:0] csr_num;
   logic [31:0] csr_rvalue;
   logic        csr_we;
   logic [31:0] csr_wmask;
   logic [31:0] csr_wvalue;

   modport master (output csr_num, csr_we, csr_wmask, csr_wvalue, input csr_rvalue);
   modport slave  (input csr_num, csr_we, csr_wmask, csr_wvalue, output csr_rvalue);
endinterface

// File: rtl/csr_timer_chan.sv
// rtl/csr_timer_chan.sv - one countdown timer channel: TCFG, counter and sticky pending bit
module csr_timer_chan
   import csr_timer_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_tick,
   input  logic             i_cfg_we,
   input  logic [CNT_W-1:0] i_wmask,
   input  logic [CNT_W-1:0] i_wvalue,
   input  logic             i_clr,
   output logic [CNT_W-1:0] o_cfg,
   output logic [CNT_W-1:0] o_cnt,
   output logic             o_pending
);

   logic [CNT_W-1:0] r_cfg;
   logic [CNT_W-1:0] r_cnt;
   logic             r_pending;
   logic [CNT_W-1:0] w_cfg_new;
   logic [CNT_W-1:0] w_reload;
   logic             w_count;
   logic             w_fire;

   assign w_cfg_new = (i_wmask & i_wvalue) | (~i_wmask & r_cfg);
   assign w_reload  = {r_cfg[CNT_W-1:TCFG_INIT_LSB], 2'b00};

   // Any TCFG write suppresses counting that cycle: it either reloads or freezes.
   assign w_count = !i_cfg_we && r_cfg[TCFG_EN_BIT] && i_tick && (r_cnt != '0);
   assign w_fire  = w_count && (r_cnt == CNT_W'(1));

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_cfg     <= '0;
         r_cnt     <= '0;
         r_pending <= 1'b0;
      end else begin
         if (i_cfg_we) begin
            r_cfg <= w_cfg_new;
            if (w_cfg_new[TCFG_EN_BIT])
               r_cnt <= {w_cfg_new[CNT_W-1:TCFG_INIT_LSB], 2'b00};
         end else if (w_count) begin
            if (w_fire)
               r_cnt <= r_cfg[TCFG_PER_BIT] ? w_reload : '0;
            else
               r_cnt <= r_cnt - CNT_W'(1);
         end

         if (w_fire)
            r_pending <= 1'b1;
         else if (i_clr)
            r_pending <= 1'b0;
      end
   end

   assign o_cfg     = r_cfg;
   assign o_cnt     = r_cnt;
   assign o_pending = r_pending;

endmodule

// File: rtl/csr_timer_intc.sv
// rtl/csr_timer_intc.sv - multi-channel timer and interrupt-pending CSR unit
module csr_timer_intc
   import csr_timer_pkg::*;
#(
   parameter int          NTIMER   = 2,
   parameter int          CNT_W    = 32,
   parameter int          NHWI     = 8,
   parameter int          PRESC    = 1,
   parameter logic [13:0] CSR_BASE = 14'h40
) (
   input  logic                                i_clk,
   input  logic                                i_reset,
   csr_timer_intc_if.slave                     bus,
   input  logic [((NHWI > 0) ? NHWI : 1)-1:0]  i_hw_int_in,
   input  logic                                i_global_ie,
   output logic [NTIMER+NHWI-1:0]              o_irq_pending,
   output logic                                o_has_int
);

   localparam int NIRQ = NTIMER + NHWI;

   if (!presc_ok(PRESC) || !cnt_w_ok(CNT_W) || NTIMER < 1 || NTIMER > 4 || NHWI < 0 || NHWI > 8) begin : g_bad_param
      $error("csr_timer_intc: parameter out of range");
   end

   logic [13:0]      w_off;
   logic [NTIMER-1:0] w_cfg_we;
   logic [NTIMER-1:0] w_clr;
   logic [NTIMER-1:0] w_tpend;
   logic [CNT_W-1:0] w_cfg [NTIMER];
   logic [CNT_W-1:0] w_cnt [NTIMER];
   logic [NIRQ-1:0]  w_pend;
   logic [NIRQ-1:0]  r_imask;
   logic [31:0]      w_rvalue;
   logic             w_tick;

   assign w_off = bus.csr_num - CSR_BASE;

   if (PRESC == 1) begin : g_no_presc
      assign w_tick = 1'b1;
   end else begin : g_presc
      localparam int PS_W = $clog2(PRESC);
      logic [PS_W-1:0] r_presc;
      assign w_tick = (r_presc == PS_W'(PRESC - 1));
      always_ff @(posedge i_clk) begin
         if (i_reset || w_tick)
            r_presc <= '0;
         else
            r_presc <= r_presc + PS_W'(1);
      end
   end

   always_comb begin
      w_cfg_we = '0;
      w_clr    = '0;
      for (int i = 0; i < NTIMER; i++) begin
         w_cfg_we[i] = bus.csr_we && (w_off == 14'(CHAN_STRIDE * i + OFF_TCFG));
         w_clr[i]    = bus.csr_we && (w_off == 14'(CHAN_STRIDE * i + OFF_TICLR))
                       && bus.csr_wmask[0] && bus.csr_wvalue[0];
      end
   end

   for (genvar g = 0; g < NTIMER; g++) begin : g_chan
      csr_timer_chan #(.CNT_W(CNT_W)) u_chan (
         .i_clk     (i_clk),
         .i_reset   (i_reset),
         .i_tick    (w_tick),
         .i_cfg_we  (w_cfg_we[g]),
         .i_wmask   (bus.csr_wmask[CNT_W-1:0]),
         .i_wvalue  (bus.csr_wvalue[CNT_W-1:0]),
         .i_clr     (w_clr[g]),
         .o_cfg     (w_cfg[g]),
         .o_cnt     (w_cnt[g]),
         .o_pending (w_tpend[g])
      );
   end

   // Hardware lines are level-following: one sampling flop, no latch, no clear.
   if (NHWI > 0) begin : g_hwi
      logic [NHWI-1:0] r_hwi;
      always_ff @(posedge i_clk) begin
         if (i_reset)
            r_hwi <= '0;
         else
            r_hwi <= i_hw_int_in;
      end
      assign w_pend = {r_hwi, w_tpend};
   end else begin : g_no_hwi
      assign w_pend = w_tpend;
   end

   always_ff @(posedge i_clk) begin
      if (i_reset)
         r_imask <= '0;
      else if (bus.csr_we && (w_off == 14'(OFF_IMASK)))
         r_imask <= (bus.csr_wmask[NIRQ-1:0] & bus.csr_wvalue[NIRQ-1:0])
                  | (~bus.csr_wmask[NIRQ-1:0] & r_imask);
   end

   always_comb begin
      w_rvalue = '0;
      for (int i = 0; i < NTIMER; i++) begin
         if (w_off == 14'(CHAN_STRIDE * i + OFF_TCFG))
            w_rvalue = 32'(w_cfg[i]);
         if (w_off == 14'(CHAN_STRIDE * i + OFF_TVAL))
            w_rvalue = 32'(w_cnt[i]);
      end
      if (w_off == 14'(OFF_IMASK))
         w_rvalue = 32'(r_imask);
      if (w_off == 14'(OFF_IPEND))
         w_rvalue = 32'(w_pend);
   end

   assign bus.csr_rvalue = w_rvalue;
   assign o_irq_pending  = w_pend;
   assign o_has_int      = i_global_ie & (|(w_pend & r_imask));

endmodule

// File: tb/tb_csr_timer_intc.sv
// tb/tb_csr_timer_intc.sv - directed table and sequence bench for csr_timer_intc
module tb_csr_timer_intc;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic [7:0] hw, hw2;
   logic       gie, gie2;
   logic [9:0] pend, pend2;
   logic       has, has2;

   csr_timer_intc_if ifc ();
   csr_timer_intc_if ifc2 ();

   csr_timer_intc dut (
      .i_clk(clk), .i_reset(rst), .bus(ifc), .i_hw_int_in(hw),
      .i_global_ie(gie), .o_irq_pending(pend), .o_has_int(has)
   );

   csr_timer_intc #(.PRESC(4)) dut4 (
      .i_clk(clk), .i_reset(rst), .bus(ifc2), .i_hw_int_in(hw2),
      .i_global_ie(gie2), .o_irq_pending(pend2), .o_has_int(has2)
   );

   typedef struct {
      logic [13:0] num;
      logic        we;
      logic [31:0] wmask;
      logic [31:0] wvalue;
      logic [7:0]  hw;
      logic        gie;
      logic [31:0] exp_rd;
      logic [9:0]  exp_pend;
      logic        exp_has;
   } vec_t;

   vec_t tbl[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic add(input logic [13:0] num, input logic we, input logic [31:0] m, input logic [31:0] v,
                      input logic [7:0] h, input logic g, input logic [31:0] er, input logic [9:0] ep, input logic eh);
      vec_t t;
      t.num = num; t.we = we; t.wmask = m; t.wvalue = v; t.hw = h; t.gie = g;
      t.exp_rd = er; t.exp_pend = ep; t.exp_has = eh;
      tbl.push_back(t);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic chk_rng(input string name, input int act, input int lo, input int hi);
      n_checks++;
      if (act < lo || act > hi) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
      end
   endtask

   task automatic drive(input bit sel, input logic [13:0] num, input logic we, input logic [31:0] m, input logic [31:0] v);
      if (sel) begin
         ifc2.csr_num = num; ifc2.csr_we = we; ifc2.csr_wmask = m; ifc2.csr_wvalue = v;
      end else begin
         ifc.csr_num = num; ifc.csr_we = we; ifc.csr_wmask = m; ifc.csr_wvalue = v;
      end
   endtask

   // Called at a negedge: write commits on the next posedge, returns at the following negedge.
   task automatic wr(input bit sel, input logic [13:0] num, input logic [31:0] m, input logic [31:0] v);
      drive(sel, num, 1'b1, m, v);
      @(negedge clk);
      drive(sel, num, 1'b0, 32'h0, 32'h0);
   endtask

   task automatic rd(input bit sel, input logic [13:0] num, output logic [31:0] val);
      drive(sel, num, 1'b0, 32'h0, 32'h0);
      #1;
      val = sel ? ifc2.csr_rvalue : ifc.csr_rvalue;
   endtask

   task automatic chk_rd(input bit sel, input string name, input logic [13:0] num, input logic [31:0] exp);
      logic [31:0] v;
      rd(sel, num, v);
      chk(name, v, exp);
   endtask

   initial begin
      logic [31:0] v;
      int          n;

      rst = 1'b1; hw = '0; hw2 = '0; gie = 1'b0; gie2 = 1'b0;
      drive(0, 14'h0, 1'b0, 32'h0, 32'h0);
      drive(1, 14'h0, 1'b0, 32'h0, 32'h0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      //  num     we  wmask         wvalue        hw     gie  rd            pend      has
      add(14'h40, 0, 32'h0,        32'h0,        8'h00, 0, 32'h0,        10'h000, 0);
      add(14'h41, 0, 32'h0,        32'h0,        8'h00, 0, 32'h0,        10'h000, 0);
      add(14'h44, 0, 32'h0,        32'h0,        8'h00, 0, 32'h0,        10'h000, 0);
      add(14'h45, 0, 32'h0,        32'h0,        8'h00, 0, 32'h0,        10'h000, 0);
      add(14'h50, 0, 32'h0,        32'h0,        8'h00, 0, 32'h0,        10'h000, 0);
      add(14'h51, 0, 32'h0,        32'h0,        8'h00, 0, 32'h0,        10'h000, 0);
      add(14'h3F, 0, 32'h0,        32'h0,        8'h00, 0, 32'h0,        10'h000, 0);
      add(14'h40, 1, 32'hFFFFFFFF, 32'h10,       8'h00, 0, 32'h0,        10'h000, 0);
      add(14'h40, 0, 32'h0,        32'h0,        8'h00, 0, 32'h10,       10'h000, 0);
      add(14'h41, 0, 32'h0,        32'h0,        8'h00, 0, 32'h0,        10'h000, 0);
      add(14'h40, 1, 32'hF0,       32'hFFFFFF2F, 8'h00, 0, 32'h10,       10'h000, 0);
      add(14'h40, 0, 32'h0,        32'h0,        8'h00, 0, 32'h20,       10'h000, 0);
      add(14'h40, 1, 32'hFFFFFFFF, 32'h0,        8'h00, 0, 32'h20,       10'h000, 0);
      add(14'h50, 1, 32'hFFF,      32'hFFFFFFFF, 8'h00, 0, 32'h0,        10'h000, 0);
      add(14'h50, 0, 32'h0,        32'h0,        8'h00, 0, 32'h3FF,      10'h000, 0);
      add(14'h51, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 8'h00, 0, 32'h0,        10'h000, 0);
      add(14'h51, 0, 32'h0,        32'h0,        8'h00, 0, 32'h0,        10'h000, 0);
      add(14'h50, 1, 32'h3FF,      32'h0,        8'h00, 0, 32'h3FF,      10'h000, 0);
      add(14'h51, 0, 32'h0,        32'h0,        8'h08, 1, 32'h0,        10'h000, 0);
      add(14'h51, 0, 32'h0,        32'h0,        8'h08, 1, 32'h20,       10'h020, 0);
      add(14'h50, 1, 32'h3FF,      32'h20,       8'h08, 1, 32'h0,        10'h020, 0);
      add(14'h50, 0, 32'h0,        32'h0,        8'h08, 1, 32'h20,       10'h020, 1);
      add(14'h50, 0, 32'h0,        32'h0,        8'h08, 0, 32'h20,       10'h020, 0);
      add(14'h51, 0, 32'h0,        32'h0,        8'h00, 1, 32'h20,       10'h020, 1);
      add(14'h51, 0, 32'h0,        32'h0,        8'h00, 1, 32'h0,        10'h000, 0);
      add(14'h43, 0, 32'h0,        32'h0,        8'h00, 0, 32'h0,        10'h000, 0);
      add(14'h4C, 0, 32'h0,        32'h0,        8'h00, 0, 32'h0,        10'h000, 0);
      add(14'h50, 1, 32'hFFFFFFFF, 32'h0,        8'h00, 0, 32'h20,       10'h000, 0);

      for (int i = 0; i < tbl.size(); i++) begin
         drive(0, tbl[i].num, tbl[i].we, tbl[i].wmask, tbl[i].wvalue);
         hw  = tbl[i].hw;
         gie = tbl[i].gie;
         #1;
         chk($sformatf("vec%0d_rvalue", i), ifc.csr_rvalue, tbl[i].exp_rd);
         chk($sformatf("vec%0d_pend", i), 32'(pend), 32'(tbl[i].exp_pend));
         chk($sformatf("vec%0d_has_int", i), 32'(has), 32'(tbl[i].exp_has));
         @(negedge clk);
      end
      drive(0, 14'h0, 1'b0, 32'h0, 32'h0);
      hw = '0;

      // One-shot, initval=2
      gie = 1'b1;
      wr(0, 14'h50, 32'hFFFFFFFF, 32'h1);
      wr(0, 14'h40, 32'hFFFFFFFF, 32'h9);
      for (int k = 8; k >= 1; k--) begin
         chk_rd(0, $sformatf("oneshot_tval_%0d", k), 14'h41, 32'(k));
         chk("oneshot_pend_early", 32'(pend[0]), 32'h0);
         @(negedge clk);
      end
      chk("oneshot_fire", 32'(pend[0]), 32'h1);
      chk("oneshot_has_int", 32'(has), 32'h1);
      repeat (3) @(negedge clk);
      chk_rd(0, "oneshot_idle_tval", 14'h41, 32'h0);
      chk("oneshot_pend_hold", 32'(pend[0]), 32'h1);
      wr(0, 14'h42, 32'h1, 32'h1);
      chk("ticlr0_pend", 32'(pend[0]), 32'h0);
      chk("ticlr0_has_int", 32'(has), 32'h0);
      wr(0, 14'h40, 32'hFFFFFFFF, 32'h0);

      // Periodic, initval=1
      wr(0, 14'h44, 32'hFFFFFFFF, 32'h7);
      for (int j = 0; j < 9; j++) begin
         chk_rd(0, $sformatf("periodic_tval_%0d", j), 14'h45, 32'(4 - (j % 4)));
         chk($sformatf("periodic_pend_%0d", j), 32'(pend[1]), 32'(j >= 4));
         @(negedge clk);
      end
      wr(0, 14'h46, 32'hFFFFFFFF, 32'h1);
      chk("periodic_clear", 32'(pend[1]), 32'h0);
      chk_rd(0, "periodic_tval_after_clear", 14'h45, 32'h2);
      @(negedge clk);
      chk_rd(0, "periodic_tval_pre_fire", 14'h45, 32'h1);
      wr(0, 14'h46, 32'hFFFFFFFF, 32'h1);
      chk("periodic_fire_beats_clear", 32'(pend[1]), 32'h1);
      chk_rd(0, "periodic_reload", 14'h45, 32'h4);
      wr(0, 14'h44, 32'hFFFFFFFF, 32'h0);
      repeat (3) @(negedge clk);
      chk_rd(0, "periodic_frozen_tval", 14'h45, 32'h4);
      chk_rd(0, "periodic_tcfg_off", 14'h44, 32'h0);

      // Prescaler build, initval=1 one-shot
      chk_rd(1, "presc_reset_tval", 14'h41, 32'h0);
      wr(1, 14'h40, 32'hFFFFFFFF, 32'h5);
      chk_rd(1, "presc_load", 14'h41, 32'h4);
      n = 0;
      while (!pend2[0] && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk_rng("presc_fire_delay", n, 13, 16);
      wr(1, 14'h42, 32'h1, 32'h1);
      chk("presc_clear", 32'(pend2[0]), 32'h0);
      wr(1, 14'h40, 32'hFFFFFFFF, 32'h5);
      repeat (6) @(negedge clk);
      rd(1, 14'h41, v);
      chk_rng("presc_midcount_tval", int'(v), 2, 3);
      wr(1, 14'h40, 32'hFFFFFFFF, 32'h5);
      chk_rd(1, "presc_rewrite_reload", 14'h41, 32'h4);
      n = 0;
      while (!pend2[0] && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk_rng("presc_restart_delay", n, 13, 16);

      // Reset on the edge that would otherwise fire
      wr(0, 14'h40, 32'hFFFFFFFF, 32'h9);
      repeat (7) @(negedge clk);
      chk_rd(0, "rst_pre_tval", 14'h41, 32'h1);
      rst = 1'b1;
      @(negedge clk);
      chk("rst_no_fire_pend", 32'(pend), 32'h0);
      chk("rst_has_int", 32'(has), 32'h0);
      chk_rd(0, "rst_tval", 14'h41, 32'h0);
      chk_rd(0, "rst_tcfg", 14'h40, 32'h0);
      chk_rd(0, "rst_imask", 14'h50, 32'h0);
      rst = 1'b0;
      @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
